// File: rtl/tsi_pkg.sv
// Shared constants and types for the TSI board-conditioning slice.
package tsi_pkg;

   localparam int TSI_SW_W        = 7;
   localparam int TSI_LED_W       = 16;
   localparam int TSI_SYNC_STAGES = 2;
   localparam int TSI_DB_CNT      = 1_000_000;

   typedef enum logic {
      DB_STABLE = 1'b0,
      DB_COUNT  = 1'b1
   } db_state_e;

endpackage

// File: rtl/tsi_cond_if.sv
// Pad-side bundle of tsi_cond: raw board inputs in, conditioned levels out.
interface tsi_cond_if
   import tsi_pkg::*;
#(
   parameter int SW_W  = TSI_SW_W,
   parameter int LED_W = TSI_LED_W
);
   logic [SW_W-1:0]  sw_I;
   logic             RX_I;
   logic             TX_I;
   logic [LED_W-1:0] LEDs_I;
   logic [SW_W-1:0]  sw_O;
   logic             sw_chg_O;
   logic             RX_O;
   logic             TX_O;
   logic [LED_W-1:0] LEDs_O;

   modport master (
      output sw_I, RX_I, TX_I, LEDs_I,
      input  sw_O, sw_chg_O, RX_O, TX_O, LEDs_O
   );

   modport slave (
      input  sw_I, RX_I, TX_I, LEDs_I,
      output sw_O, sw_chg_O, RX_O, TX_O, LEDs_O
   );
endinterface

// File: rtl/BUFG.sv
// Behavioural stand-in for the vendor global clock buffer; replaced by the vendor library cell in implementation.
module BUFG (
   input  logic I,
   output logic O
);
   assign O = I;
endmodule

// File: rtl/IBUF.sv
// Behavioural stand-in for the vendor input pad buffer.
module IBUF (
   input  logic I,
   output logic O
);
   assign O = I;
endmodule

// File: rtl/OBUF.sv
// Behavioural stand-in for the vendor output pad buffer.
module OBUF (
   input  logic I,
   output logic O
);
   assign O = I;
endmodule

// File: rtl/tsi_debounce.sv
// One switch bit: SYNC_STAGES-deep synchronizer feeding a STABLE/COUNT debouncer.
module tsi_debounce
   import tsi_pkg::*;
#(
   parameter int SYNC_STAGES = TSI_SYNC_STAGES,
   parameter int DB_CNT      = TSI_DB_CNT
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic toggle
);
   localparam int            CNT_W    = $clog2(DB_CNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_bit_s;
   db_state_e              state_r;
   db_state_e              state_next_s;
   logic [CNT_W-1:0]       cnt_r;
   logic [CNT_W-1:0]       cnt_next_s;
   logic                   level_r;
   logic                   toggle_s;

   // synchronizer chain, reset low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
      end
   end

   assign sync_bit_s = sync_r[SYNC_STAGES-1];

   // debouncer state, counter and debounced level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= DB_STABLE;
         cnt_r   <= '0;
         level_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
         level_r <= level_r ^ toggle_s;
      end
   end

   // next state: the counter stops at DB_CNT-1, where the level flips instead of wrapping
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      toggle_s     = 1'b0;
      case (state_r)
         DB_STABLE: begin
            if (sync_bit_s != level_r) begin
               state_next_s = DB_COUNT;
               cnt_next_s   = CNT_ONE;
            end else begin
               cnt_next_s   = '0;
            end
         end
         DB_COUNT: begin
            if (sync_bit_s == level_r) begin
               state_next_s = DB_STABLE;
               cnt_next_s   = '0;
            end else if (cnt_r == CNT_LAST) begin
               state_next_s = DB_STABLE;
               cnt_next_s   = '0;
               toggle_s     = 1'b1;
            end else begin
               cnt_next_s   = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_next_s = DB_STABLE;
            cnt_next_s   = '0;
         end
      endcase
   end

   assign level  = level_r;
   assign toggle = toggle_s;
endmodule

// File: rtl/tsi_cond.sv
// Board-level conditioning: clock buffering, core reset synchronizer, switch debouncing,
// RX synchronization and registered TX/LED pin drive.
module tsi_cond
   import tsi_pkg::*;
#(
   parameter int SW_W        = TSI_SW_W,
   parameter int LED_W       = TSI_LED_W,
   parameter int SYNC_STAGES = TSI_SYNC_STAGES,
   parameter int DB_CNT      = TSI_DB_CNT
) (
   input  logic       clk_I,
   input  logic       reset_I,
   output logic       clk_O,
   output logic       reset_O,
   tsi_cond_if.slave  bus
);
   logic                   clk_s;
   logic [SW_W-1:0]        sw_pad_s;
   logic                   rx_pad_s;
   logic [SYNC_STAGES-1:0] rst_sync_r;
   logic [SYNC_STAGES-1:0] rx_sync_r;
   logic [SW_W-1:0]        sw_db_s;
   logic [SW_W-1:0]        toggle_s;
   logic                   sw_chg_r;
   logic                   tx_r;
   logic [LED_W-1:0]       leds_r;
   logic                   tx_pad_s;
   logic [LED_W-1:0]       leds_pad_s;

   BUFG u_bufg (.I(clk_I), .O(clk_s));
   assign clk_O = clk_s;

   IBUF u_ibuf_rx (.I(bus.RX_I), .O(rx_pad_s));

   for (genvar g = 0; g < SW_W; g++) begin : g_sw
      IBUF u_ibuf_sw (.I(bus.sw_I[g]), .O(sw_pad_s[g]));

      tsi_debounce #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_CNT      (DB_CNT)
      ) u_db (
         .clk    (clk_s),
         .rst    (reset_I),
         .raw    (sw_pad_s[g]),
         .level  (sw_db_s[g]),
         .toggle (toggle_s[g])
      );
   end

   // core reset: async assert, deassert after SYNC_STAGES clean edges
   always_ff @(posedge clk_s or posedge reset_I) begin
      if (reset_I) begin
         rst_sync_r <= '1;
      end else begin
         rst_sync_r <= {rst_sync_r[SYNC_STAGES-2:0], 1'b0};
      end
   end

   // RX synchronizer idles high like the UART line
   always_ff @(posedge clk_s or posedge reset_I) begin
      if (reset_I) begin
         rx_sync_r <= '1;
      end else begin
         rx_sync_r <= {rx_sync_r[SYNC_STAGES-2:0], rx_pad_s};
      end
   end

   // change pulse lands in the same cycle as the new sw_O value; many bits give one pulse
   always_ff @(posedge clk_s or posedge reset_I) begin
      if (reset_I) begin
         sw_chg_r <= 1'b0;
      end else begin
         sw_chg_r <= |toggle_s;
      end
   end

   // TX/LED pin drive registers, TX idle high
   always_ff @(posedge clk_s or posedge reset_I) begin
      if (reset_I) begin
         tx_r   <= 1'b1;
         leds_r <= '0;
      end else begin
         tx_r   <= bus.TX_I;
         leds_r <= bus.LEDs_I;
      end
   end

   OBUF u_obuf_tx (.I(tx_r), .O(tx_pad_s));
   for (genvar l = 0; l < LED_W; l++) begin : g_led
      OBUF u_obuf_led (.I(leds_r[l]), .O(leds_pad_s[l]));
   end

   assign reset_O      = rst_sync_r[SYNC_STAGES-1];
   assign bus.RX_O     = rx_sync_r[SYNC_STAGES-1];
   assign bus.sw_O     = sw_db_s;
   assign bus.sw_chg_O = sw_chg_r;
   assign bus.TX_O     = tx_pad_s;
   assign bus.LEDs_O   = leds_pad_s;
endmodule

// File: doc/tsi_cond.md
TSI_COND -- requirements
Module: tsi_cond

Interface
REQ-001 Parameter SW_W, default 7, number of switch inputs (baud_value[3:0], EIGHT, PEN, OHEL).
REQ-002 Parameter LED_W, default 16, LED output width.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth (legal range 2..4).
REQ-004 Parameter DB_CNT, default 1_000_000, debounce stable-time in clk cycles (10 ms at 100 MHz); legal minimum 2.
REQ-005 clk_I  input  1  board clock; sole clock; the block is in a single clock domain.
REQ-006 reset_I  input  1  board reset, asynchronous, active-high.
REQ-007 sw_I  input  SW_W  raw slide-switch levels, asynchronous to clk_I.
REQ-008 RX_I  input  1  raw UART receive pin, asynchronous to clk_I.
REQ-009 TX_I  input  1  core-side UART transmit bit.
REQ-010 LEDs_I  input  LED_W  core-side LED levels.
REQ-011 clk_O  output  1  clk_I routed through a global clock buffer.
REQ-012 reset_O  output  1  core reset, asynchronous assert, synchronous deassert, active-high.
REQ-013 sw_O  output  SW_W  synchronized, debounced switch levels.
REQ-014 sw_chg_O  output  1  one-cycle pulse when any sw_O bit changes.
REQ-015 RX_O  output  1  synchronized RX level.
REQ-016 TX_O  output  1  registered TX pin drive.
REQ-017 LEDs_O  output  LED_W  registered LED pin drive.

Function
REQ-018 reset_O SHALL assert in the same instant reset_I rises and deassert on the SYNC_STAGES-th rising clk_I edge after reset_I falls.
REQ-019 Each sw_I bit and RX_I SHALL pass through a SYNC_STAGES flip-flop synchronizer before any other use.
REQ-020 Each switch bit SHALL run an independent two-state debouncer: STABLE and COUNT.
REQ-021 STABLE -> COUNT when the synchronized bit differs from the sw_O bit; counter loads 1.
REQ-022 COUNT: the counter SHALL increment while the synchronized bit still differs; if it equals sw_O again, the counter clears and the state returns to STABLE without changing sw_O.
REQ-023 COUNT: when the counter reaches DB_CNT-1 and the bit still differs, sw_O bit SHALL toggle on the next edge; counter clears; state -> STABLE.
REQ-024 Counter width SHALL be $clog2(DB_CNT); the counter never wraps.
REQ-025 Latency from a clean sw_I edge to sw_O SHALL be exactly SYNC_STAGES + DB_CNT cycles.
REQ-026 sw_chg_O SHALL be high for exactly the one cycle in which sw_O differs from its previous value; simultaneous changes of several bits produce one pulse.
REQ-027 RX_O latency SHALL be SYNC_STAGES cycles with no filtering.
REQ-028 TX_O and LEDs_O SHALL equal TX_I and LEDs_I delayed by one cycle.

Reset
REQ-029 While reset_I is high: sw_O=0, sw_chg_O=0, all debouncers STABLE with counter 0, synchronizer stages for RX = 1, for switches = 0, RX_O=1, TX_O=1 (UART idle), LEDs_O=0.
REQ-030 Reset asserted mid-count SHALL abort the count; after release, sw_O starts at 0 and re-debounces the present switch levels.
REQ-031 All state elements SHALL use reset_I asynchronously; reset_O is a driven output only, never used internally.

Structure
REQ-032 Package tsi_pkg SHALL hold the default constants (SW_W, LED_W, SYNC_STAGES, DB_CNT) and the debouncer state enumeration.
REQ-033 Sub-module tsi_debounce (single-bit synchronizer plus debouncer, parameters SYNC_STAGES and DB_CNT) SHALL be instantiated SW_W times via generate.
REQ-034 Clock and pad buffers SHALL be vendor primitives (BUFG on clock, IBUF/OBUF on pads).

Verification (bench parameters: DB_CNT=8, SYNC_STAGES=2, SW_W=7)
REQ-035 Reset pulse, then release -> reset_O falls on the 2nd edge; RX_O=1, TX_O=1, LEDs_O=0, sw_O=0.
REQ-036 sw_I[0] 0->1 held -> sw_O[0]=1 exactly 10 cycles later; sw_chg_O high for 1 cycle only.
REQ-037 sw_I[2] high for 5 cycles, then low -> sw_O unchanged; sw_chg_O never pulses.
REQ-038 sw_I 7'h00->7'h55 in one cycle -> sw_O=7'h55 after 10 cycles with a single sw_chg_O pulse.
REQ-039 reset_I asserted 4 cycles into a count -> sw_O stays 0; after release with sw_I held, sw_O updates 10 cycles after the synchronizers have sampled it.
REQ-040 RX_I toggling, TX_I toggling, LEDs_I=16'hA5C3 -> RX_O follows after 2 cycles; TX_O and LEDs_O follow after 1 cycle.
